pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register. It is the successor to the per-field stage registers (if_id, id_ex, ex_mem, mem_wb). It carries one packed payload bus with a valid/ready handshake, and it honours the existing flush_valid/stall_valid control buses. An optional two-entry skid buffer breaks the combinational ready path between stages. A saturating stall-cycle counter supports performance monitoring.

Parameters:
DATA_W, 64, payload width in bits (packed fields, e.g. pc+inst+csr+rd+data)
CTRL_IDX, 0, bit index into flush_valid_i/stall_valid_i (e.g. `CTRLBUS_MEM_WB)
SKID, 1, 1 = two-entry skid buffer (registered in_ready_o); 0 = single register, combinational in_ready_o
RESET_DATA, {DATA_W{1'b0}}, payload value after reset and after flush (NOP encoding)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush_valid_i  in  6  pipeline flush vector; bit CTRL_IDX used
stall_valid_i  in  6  pipeline stall vector; bit CTRL_IDX used
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  stage can accept a beat
in_data_i  in  DATA_W  upstream payload
out_valid_o  out  1  stage holds a valid beat
out_ready_i  in  1  downstream accepts
out_data_o  out  DATA_W  payload of head entry
stall_cnt_o  out  CNT_W  saturating count of stalled cycles with valid head

Behaviour:
- Signals: flush = flush_valid_i[CTRL_IDX], stall = stall_valid_i[CTRL_IDX].
- Handshakes: in_fire = in_valid_i & in_ready_o. out_fire = out_valid_o & out_ready_i & ~stall & ~flush.
- Storage: main entry (main_v, main_d) drives out_valid_o/out_data_o. Skid entry (skid_v, skid_d) exists only when SKID=1.
- Reset (async, immediate):
  - main_v=0, skid_v=0.
  - out_data_o=RESET_DATA, skid_d=RESET_DATA.
  - stall_cnt_o=0.
  - in_ready_o=0 while rst is high.
- Flush (highest priority, beats stall):
  - Next edge: main_v=0, skid_v=0, main_d=RESET_DATA.
  - in_ready_o=1 during a flush cycle; any upstream beat is consumed and discarded.
  - out_fire is suppressed in the flush cycle.
- Stall (no flush):
  - All state frozen.
  - in_ready_o=0 and no out_fire, regardless of out_ready_i.
- in_ready_o:
  - SKID=1: ~skid_v & ~stall | flush. Registered-state based, with no path from out_ready_i.
  - SKID=0: (~main_v | out_ready_i) & ~stall | flush.
- State machine, SKID=1 (no flush, no stall). State is {EMPTY, HALF, FULL} = {main_v=0, main_v=1 & skid_v=0, both}.
  - EMPTY: in_fire -> HALF, main_d=in_data_i. Otherwise stay.
  - HALF, out_fire & in_fire -> HALF, main_d=in_data_i.
  - HALF, out_fire only -> EMPTY.
  - HALF, in_fire only -> FULL, skid_d=in_data_i.
  - HALF, neither -> HALF.
  - FULL: in_ready_o=0. out_fire -> HALF, main_d=skid_d, skid_v=0. Otherwise stay.
- SKID=0: main loads in_data_i on in_fire. main_v = in_fire | (main_v & ~out_fire).
- Ordering and latency:
  - Beats leave strictly in acceptance order.
  - Latency in_fire to out_valid_o is 1 cycle.
  - Throughput is 1 beat/cycle when out_ready_i is held high.
- Payload values: main_d is undefined-free. When main_v=0, out_data_o holds its last value or RESET_DATA after reset/flush. Consumers gate on out_valid_o.
- Stall counter:
  - Increments when stall & main_v & ~flush.
  - Saturates at all-ones and does not wrap.
  - Cleared only by rst.
- Reset asserted mid-transfer drops all held beats; there is no partial state.

Test Plan:
- Reset: rst=1 with in_valid_i=1, data=0xA5 -> out_valid_o=0, out_data_o=RESET_DATA, in_ready_o=0, stall_cnt_o=0. Release; next edge accepts 0xA5, out_valid_o=1 one cycle later.
- Streaming (SKID=1): beats 1..8 back-to-back, out_ready_i=1 -> outputs 1..8 in order, one per cycle, no bubbles after the first.
- Backpressure: out_ready_i=0 while sending 0x11, 0x22 -> state FULL, in_ready_o=0, out_data_o=0x11. Raise out_ready_i -> 0x11 then 0x22 emitted, in_ready_o=1 after the first release.
- Stall: FULL state with stall=1 for 5 cycles and out_ready_i=1 -> no transfer, contents unchanged, stall_cnt_o=5. Set CNT_W=3 and stall 10 cycles -> stall_cnt_o=7 (saturated).
- Flush beats stall: FULL with stall=1 and flush=1 in the same cycle, in_valid_i=1 data=0x33 -> next cycle out_valid_o=0, out_data_o=RESET_DATA, 0x33 never appears at the output.
- SKID=0 build: out_ready_i toggled 1010... with continuous input -> in_ready_o follows out_ready_i combinationally while main_v=1, no beat lost or duplicated over 16 beats.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: one packed payload bus with a valid/ready
// handshake, flush/stall control taken from shared control vectors, an
// optional two-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int                DATA_W     = 64,
    parameter int                CTRL_IDX   = 0,
    parameter bit                SKID       = 1'b1,
    parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}},
    parameter int                CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        flush_valid_i,
    input  logic [5:0]        stall_valid_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Occupancy: EMPTY (nothing held), HALF (main only), FULL (main + skid).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            st, st_nxt;
    logic              flush, stall;
    logic              main_v, skid_v;
    logic              in_fire, out_fire, rdy;
    logic [DATA_W-1:0] main_d, main_d_nxt;
    logic [DATA_W-1:0] skid_d, skid_d_nxt;

    // Only one bit of each control vector belongs to this stage.
    logic unused_ctrl;
    assign unused_ctrl = ^{flush_valid_i, stall_valid_i};

    assign flush = flush_valid_i[CTRL_IDX];
    assign stall = stall_valid_i[CTRL_IDX];

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_EMPTY;
        else     st <= st_nxt;
    end

    // Next occupancy: flush empties, stall freezes, otherwise follow the handshakes.
    always_comb begin
        st_nxt = st;
        if (flush) begin
            st_nxt = ST_EMPTY;
        end else if (!stall) begin
            case (st)
                ST_EMPTY: if (in_fire) st_nxt = ST_HALF;
                ST_HALF: begin
                    if (in_fire && !out_fire && SKID) st_nxt = ST_FULL;
                    else if (!in_fire && out_fire)    st_nxt = ST_EMPTY;
                end
                ST_FULL:  if (out_fire) st_nxt = ST_HALF;
                default:  st_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs; with a skid buffer in_ready depends only on state and control.
    always_comb begin
        main_v = (st != ST_EMPTY);
        skid_v = (st == ST_FULL);
        if (SKID) rdy = (~skid_v & ~stall) | flush;
        else      rdy = ((~main_v | out_ready_i) & ~stall) | flush;
        in_ready_o  = rdy & ~rst;
        in_fire     = in_valid_i & in_ready_o;
        out_fire    = main_v & out_ready_i & ~stall & ~flush;
        out_valid_o = main_v;
        out_data_o  = main_d;
    end

    // Payload steering: new beats land in main, or in skid when main cannot drain.
    always_comb begin
        main_d_nxt = main_d;
        skid_d_nxt = skid_d;
        if (flush) begin
            main_d_nxt = RESET_DATA;
        end else if (!stall) begin
            case (st)
                ST_EMPTY: if (in_fire) main_d_nxt = in_data_i;
                ST_HALF: begin
                    if (in_fire && (out_fire || !SKID)) main_d_nxt = in_data_i;
                    else if (in_fire)                   skid_d_nxt = in_data_i;
                end
                ST_FULL:  if (out_fire) main_d_nxt = skid_d;
                default:  main_d_nxt = main_d;
            endcase
        end
    end

    // Payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_d <= RESET_DATA;
            skid_d <= RESET_DATA;
        end else begin
            main_d <= main_d_nxt;
            skid_d <= skid_d_nxt;
        end
    end

    // Stall-cycle counter: counts stalled cycles while a beat is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          stall_cnt_o <= '0;
        else if (stall && main_v && !flush) stall_cnt_o <= sat_inc(stall_cnt_o);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid build, 3-bit counter build, no-skid build.
module tb_pipe_stage_reg;

    localparam logic [7:0] RD = 8'hEE;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // main skid build
    logic [5:0] flush_v, stall_v;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [31:0] stall_cnt;

    // 3-bit counter build
    logic [5:0] stall_v3;
    logic       in_valid3, in_ready3, out_valid3;
    logic [7:0] in_data3, out_data3;
    logic [2:0] stall_cnt3;

    // no-skid build
    logic       in_valid0, in_ready0, out_valid0, out_ready0;
    logic [7:0] in_data0, out_data0;
    logic [31:0] stall_cnt0;

    pipe_stage_reg #(.DATA_W(8), .CTRL_IDX(2), .SKID(1'b1), .RESET_DATA(RD), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush_valid_i(flush_v), .stall_valid_i(stall_v),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .stall_cnt_o(stall_cnt));

    pipe_stage_reg #(.DATA_W(8), .CTRL_IDX(2), .SKID(1'b1), .RESET_DATA(RD), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .flush_valid_i(6'd0), .stall_valid_i(stall_v3),
        .in_valid_i(in_valid3), .in_ready_o(in_ready3), .in_data_i(in_data3),
        .out_valid_o(out_valid3), .out_ready_i(1'b0), .out_data_o(out_data3),
        .stall_cnt_o(stall_cnt3));

    pipe_stage_reg #(.DATA_W(8), .CTRL_IDX(2), .SKID(1'b0), .RESET_DATA(RD), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .flush_valid_i(6'd0), .stall_valid_i(6'd0),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_data_i(in_data0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_data_o(out_data0),
        .stall_cnt_o(stall_cnt0));

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (out_data !== RD) begin bad++; $display("FAIL rst_data got=%h want=%h", out_data, RD); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", in_ready); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", stall_cnt); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA5)
            begin bad++; $display("FAIL rel_accept got=%b/%h want=1/a5", out_valid, out_data); end
        // asynchronous reset while a beat is held
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== RD)
            begin bad++; $display("FAIL async_rst got=%b/%h want=0/%h", out_valid, out_data, RD); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL async_rst_ready got=%b want=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] v;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i);
            in_valid = 1'b1; in_data = v;
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || out_data !== v || in_ready !== 1'b1)
                begin bad++; $display("FAIL stream_%0d got=%b/%h/%b want=1/%h/1", i, out_valid, out_data, in_ready, v); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11)
            begin bad++; $display("FAIL bp_full got=%b/%b/%h want=0/1/11", in_ready, out_valid, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h22 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_second got=%b/%h/%b want=1/22/1", out_valid, out_data, in_ready); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
        @(negedge clk);
        in_data = 8'h55;
        @(negedge clk);
        stall_v = 6'b000100; out_ready = 1'b1; in_data = 8'h66;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", in_ready); end
        repeat (5) @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h44)
            begin bad++; $display("FAIL stall_hold got=%b/%h want=1/44", out_valid, out_data); end
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_cnt got=%0d want=5", stall_cnt); end
        stall_v = 6'd0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h55)
            begin bad++; $display("FAIL stall_release got=%b/%h want=1/55", out_valid, out_data); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || stall_cnt !== 32'd5)
            begin bad++; $display("FAIL stall_drain got=%b/%0d want=0/5", out_valid, stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        in_data = 8'h88;
        @(negedge clk);
        stall_v = 6'b000100; flush_v = 6'b000100; in_data = 8'h33;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", in_ready); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || out_data !== RD)
            begin bad++; $display("FAIL flush_clear got=%b/%h want=0/%h", out_valid, out_data, RD); end
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL flush_cnt got=%0d want=5", stall_cnt); end
        flush_v = 6'd0; stall_v = 6'd0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0)
                begin bad++; $display("FAIL flush_discard_%0d got=%b/%h want=0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_saturate();
        in_valid3 = 1'b1; in_data3 = 8'h09;
        @(negedge clk);
        in_valid3 = 1'b0; stall_v3 = 6'b000100;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                total++; if (stall_cnt3 !== 3'd5) begin bad++; $display("FAIL sat_mid got=%0d want=5", stall_cnt3); end
            end
        end
        total++; if (stall_cnt3 !== 3'd7) begin bad++; $display("FAIL sat_end got=%0d want=7", stall_cnt3); end
        total++; if (out_valid3 !== 1'b1 || out_data3 !== 8'h09)
            begin bad++; $display("FAIL sat_hold got=%b/%h want=1/09", out_valid3, out_data3); end
        stall_v3 = 6'd0;
    endtask

    task automatic test_noskid();
        int got;
        int sent;
        logic [7:0] exp_d;
        got = 0; sent = 1;
        in_valid0 = 1'b1;
        for (int cyc = 0; cyc < 64 && got < 16; cyc++) begin
            out_ready0 = (cyc % 2 == 0);
            in_data0 = sent[7:0];
            #1;
            if (out_valid0) begin
                total++; if (in_ready0 !== out_ready0)
                    begin bad++; $display("FAIL ns_ready_%0d got=%b want=%b", cyc, in_ready0, out_ready0); end
            end
            if (out_valid0 && out_ready0) begin
                got++;
                exp_d = 8'(got);
                total++; if (out_data0 !== exp_d)
                    begin bad++; $display("FAIL ns_beat_%0d got=%h want=%h", got, out_data0, exp_d); end
            end
            if (in_valid0 && in_ready0) sent++;
            @(negedge clk);
        end
        in_valid0 = 1'b0;
        total++; if (got != 16) begin bad++; $display("FAIL ns_count got=%0d want=16", got); end
    endtask

    initial begin
        rst = 1'b1;
        flush_v = 6'd0; stall_v = 6'd0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        stall_v3 = 6'd0; in_valid3 = 1'b0; in_data3 = 8'd0;
        in_valid0 = 1'b0; in_data0 = 8'd0; out_ready0 = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_flush();
        test_saturate();
        test_noskid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
